// File: rtl/sdram_pkg.sv
// Shared sdram port widths, request payload type and sizing helpers.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    typedef struct packed {
        logic                    we;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } sdram_req_t;

    // Width of a counter or index holding values 0..n-1, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a requester tag (owner index) for nreq requesters.
    function automatic int tag_width(input int nreq);
        return idx_width(nreq);
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per in-flight sdram access.
module sdram_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_tag,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full, even if an entry leaves in the same cycle.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram port among NREQ requesters, with burst
// lock for row locality and in-order response steering through a tag FIFO.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              a_valid,
    output logic [NREQ-1:0]              a_ready,
    input  logic [NREQ-1:0]              a_we,
    input  logic [SDRAM_ADDR_W*NREQ-1:0] a_addr,
    input  logic [SDRAM_DATA_W*NREQ-1:0] a_data,
    output logic [NREQ-1:0]              b_valid,
    output logic [SDRAM_DATA_W-1:0]      b_data,
    output logic                         s_avalid,
    output logic                         s_we,
    output logic [SDRAM_ADDR_W-1:0]      s_addr,
    output logic [SDRAM_DATA_W-1:0]      s_data,
    input  logic                         s_aready,
    input  logic                         s_bvalid,
    input  logic [SDRAM_DATA_W-1:0]      s_bdata,
    output logic                         err
);
    localparam int TAG_W   = tag_width(NREQ);
    localparam int BURST_W = idx_width(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    logic [TAG_W-1:0]   grant;
    logic [TAG_W-1:0]   next_grant;
    logic [TAG_W-1:0]   tag_head;
    logic [BURST_W-1:0] burst_cnt;
    sdram_req_t         sel;
    logic               sel_valid;
    logic               found;
    logic               fifo_full;
    logic               fifo_empty;
    logic               hs;
    logic               rearb;
    logic               resp_pop;

    // Select the payload of the current owner.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == TAG_W'(i)) begin
                sel_valid = a_valid[i];
                sel.we    = a_we[i];
                sel.addr  = a_addr[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                sel.data  = a_data[i*SDRAM_DATA_W +: SDRAM_DATA_W];
            end
        end
    end

    assign s_avalid = sel_valid && !fifo_full;
    assign s_we     = sel.we;
    assign s_addr   = sel.addr;
    assign s_data   = sel.data;
    assign hs       = s_avalid && s_aready;

    // Only the owner sees ready; it does not depend on the owner's own valid.
    always_comb begin
        a_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_ready[i] = (grant == TAG_W'(i)) && s_aready && !fifo_full;
        end
    end

    // Search grant+1, grant+2, ... (wrapping, ending at grant) for the first valid requester.
    always_comb begin
        next_grant = grant;
        found      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == (int'(grant) + k) % NREQ) && a_valid[j]) begin
                    next_grant = TAG_W'(j);
                    found      = 1'b1;
                end
            end
        end
    end

    assign rearb = !sel_valid || (hs && (burst_cnt == BURST_LAST));

    // Owner and burst length; a finished burst or an idle owner hands over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            burst_cnt <= '0;
        end else if (rearb) begin
            grant     <= next_grant;
            burst_cnt <= '0;
        end else if (hs) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // A response with nothing outstanding is a protocol error held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (s_bvalid && fifo_empty) begin
            err <= 1'b1;
        end
    end

    sdram_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (hs),
        .push_tag (grant),
        .pop      (s_bvalid),
        .head     (tag_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign resp_pop = s_bvalid && !fifo_empty;
    assign b_data   = s_bdata;

    // Steer the response strobe to the requester at the head of the tag FIFO.
    always_comb begin
        b_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            b_valid[i] = resp_pop && (tag_head == TAG_W'(i));
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: requester queues and an sdram model drive the DUT,
// a scoreboard queue holds the expected owner/data of each accepted access.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int NREQ      = 2;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      a_valid, a_ready, a_we, b_valid;
    logic [24*NREQ-1:0]   a_addr;
    logic [16*NREQ-1:0]   a_data;
    logic [15:0]          b_data, s_data, s_bdata;
    logic [23:0]          s_addr;
    logic                 s_avalid, s_we, s_aready, s_bvalid, err;

    typedef struct { logic we; logic [23:0] addr; logic [15:0] data; } txn_t;
    typedef struct { int owner; logic [15:0] data; } resp_t;
    typedef struct { int cyc; int owner; } hs_t;

    txn_t        req_q [NREQ][$];
    resp_t       pending[$];
    resp_t       exp_q[$];
    hs_t         hs_log[$];
    logic [15:0] mem [logic [23:0]];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          aready_prob = 100;
    int          resp_prob = 100;
    bit          one_shot = 1'b0;
    bit          spur_req = 1'b0;
    bit          exp_err = 1'b0;
    int          resp_cnt [NREQ];
    logic [15:0] last_data [NREQ];

    sdram_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_data(b_data),
        .s_avalid(s_avalid), .s_we(s_we), .s_addr(s_addr), .s_data(s_data),
        .s_aready(s_aready), .s_bvalid(s_bvalid), .s_bdata(s_bdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [15:0] rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : ~a[15:0];
    endfunction

    task automatic add(input int i, input bit we, input logic [23:0] a, input logic [15:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        req_q[i].push_back(t);
    endtask

    // Requesters and sdram model: observe at negedge, update just after posedge.
    initial begin : bfm
        txn_t  t;
        resp_t r;
        hs_t   h;
        int    hs_owner;
        bit    hs_seen;
        bit    presented;
        int    wait_cnt [NREQ];
        presented = 1'b0;
        hs_owner  = -1;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        a_valid = '0; a_we = '0; a_addr = '0; a_data = '0;
        s_aready = 1'b0; s_bvalid = 1'b0; s_bdata = '0;
        forever begin
            @(negedge clk);
            hs_seen = 1'b0;
            if (rst_n) begin
                if (pending.size() == DEPTH)
                    chk(a_ready == '0 && !s_avalid, "full_block", {a_ready, s_avalid}, 0);
                if (a_ready != '0)
                    chk(s_aready && $onehot(a_ready), "ready_qual", {s_aready, a_ready}, {1'b1, a_ready});
                if (s_avalid && s_aready) begin
                    hs_owner = -1;
                    for (int i = 0; i < NREQ; i++)
                        if (a_ready[i] && a_valid[i]) hs_owner = i;
                    chk(hs_owner >= 0, "hs_owner", a_ready, a_valid);
                    if (hs_owner >= 0) begin
                        t = req_q[hs_owner][0];
                        chk(s_we == t.we && s_addr == t.addr && s_data == t.data, "hs_payload",
                            {s_we, s_addr, s_data}, {t.we, t.addr, t.data});
                        hs_seen = 1'b1;
                    end
                end else if ((a_ready & a_valid) != '0) begin
                    chk(1'b0, "accept_without_hs", a_ready & a_valid, 0);
                end
            end
            @(posedge clk);
            #1;
            cycle++;
            if (!rst_n) begin
                pending.delete();
                exp_q.delete();
                presented = 1'b0;
                a_valid = '0;
                s_aready = 1'b0;
                s_bvalid = 1'b0;
                for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
            end else begin
                if (presented && pending.size() > 0) void'(pending.pop_front());
                if (hs_seen) begin
                    t = req_q[hs_owner].pop_front();
                    r.owner = hs_owner;
                    if (t.we) begin
                        mem[t.addr] = t.data;
                        r.data = 16'($urandom);
                    end else begin
                        r.data = rd(t.addr);
                    end
                    pending.push_back(r);
                    exp_q.push_back(r);
                    h.cyc = cycle; h.owner = hs_owner;
                    hs_log.push_back(h);
                end
                presented = 1'b0;
                s_bvalid  = 1'b0;
                s_bdata   = 16'($urandom);
                if (spur_req) begin
                    s_bvalid = 1'b1;
                    spur_req = 1'b0;
                end else if (pending.size() > 0 && (one_shot || $urandom_range(99) < resp_prob)) begin
                    s_bvalid  = 1'b1;
                    s_bdata   = pending[0].data;
                    presented = 1'b1;
                    one_shot  = 1'b0;
                end
                s_aready = ($urandom_range(99) < aready_prob);
                for (int i = 0; i < NREQ; i++) begin
                    a_valid[i] = (req_q[i].size() > 0);
                    if (a_valid[i]) begin
                        a_we[i] = req_q[i][0].we;
                        a_addr[i*24 +: 24] = req_q[i][0].addr;
                        a_data[i*16 +: 16] = req_q[i][0].data;
                    end
                    if (a_valid[i] && !(hs_seen && hs_owner == i)) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (wait_cnt[i] > 400) begin
                        chk(1'b0, "starvation", i, 0);
                        wait_cnt[i] = 0;
                    end
                end
            end
        end
    end

    // Response monitor: every response strobe pops and checks the scoreboard.
    resp_t            mon_r;
    logic [NREQ-1:0]  mon_bv;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_err = 1'b0;
        end else begin
            chk(err == exp_err, "err", err, exp_err);
            if (s_bvalid || b_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk(b_valid == '0, "spurious_bvalid", b_valid, 0);
                    if (s_bvalid) exp_err = 1'b1;
                end else begin
                    mon_r  = exp_q.pop_front();
                    mon_bv = NREQ'(1 << mon_r.owner);
                    chk(b_valid == mon_bv && b_data == mon_r.data, "response",
                        {b_valid, b_data}, {mon_bv, mon_r.data});
                    resp_cnt[mon_r.owner]++;
                    last_data[mon_r.owner] = b_data;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) req_q[i].delete();
        one_shot = 1'b0;
        spur_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic start_test();
        @(posedge clk);
        hs_log.delete();
        for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    endtask

    task automatic wait_idle(input int limit);
        int  n;
        bit  idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < limit) begin
            @(posedge clk);
            #2;
            idle = (pending.size() == 0);
            for (int i = 0; i < NREQ; i++) if (req_q[i].size() > 0) idle = 1'b0;
            n++;
        end
        chk(idle, "drain", pending.size(), 0);
    endtask

    initial begin : global_timeout
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < NREQ; i++) begin resp_cnt[i] = 0; last_data[i] = '0; end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk(!s_avalid && b_valid == '0 && !err, "reset_outputs", {s_avalid, b_valid, err}, 0);

        // T1: three writes from requester 0 only, accepted back to back.
        start_test();
        for (int k = 0; k < 3; k++) add(0, 1'b1, 24'h000010 + 24'(k), 16'hA000 + 16'(k));
        wait_idle(100);
        chk(hs_log.size() == 3, "t1_count", hs_log.size(), 3);
        for (int k = 0; k < hs_log.size(); k++)
            chk(hs_log[k].owner == 0 && (k == 0 || hs_log[k].cyc == hs_log[k-1].cyc + 1),
                "t1_consecutive", hs_log[k].owner, 0);
        chk(resp_cnt[0] == 3 && resp_cnt[1] == 0, "t1_responses", resp_cnt[0], 3);

        // T2: both requesters busy, runs of exactly MAX_BURST.
        do_reset();
        start_test();
        for (int k = 0; k < 16; k++) begin
            add(0, 1'b1, 24'h000100 + 24'(k), 16'(k));
            add(1, 1'b1, 24'h400100 + 24'(k), 16'(k + 100));
        end
        wait_idle(300);
        chk(hs_log.size() == 32, "t2_count", hs_log.size(), 32);
        for (int k = 0; k < hs_log.size(); k++)
            chk(hs_log[k].owner == (k / MAX_BURST) % 2 && (k == 0 || hs_log[k].cyc == hs_log[k-1].cyc + 1),
                "t2_burst_run", hs_log[k].owner, (k / MAX_BURST) % 2);

        // T3: read by requester 1 interleaved with a write by requester 0.
        do_reset();
        start_test();
        mem[24'h123456] = 16'hBEEF;
        add(0, 1'b1, 24'h000200, 16'h1234);
        add(1, 1'b0, 24'h123456, 16'h0000);
        wait_idle(100);
        chk(hs_log.size() == 2 && hs_log[0].owner == 0 && hs_log[1].owner == 1, "t3_order",
            hs_log.size(), 2);
        chk(resp_cnt[0] == 1 && resp_cnt[1] == 1, "t3_responses", {resp_cnt[0][7:0], resp_cnt[1][7:0]}, 16'h0101);
        chk(last_data[1] == 16'hBEEF, "t3_read_data", last_data[1], 16'hBEEF);

        // T4: responses held, the tag FIFO limits outstanding accesses.
        do_reset();
        resp_prob = 0;
        start_test();
        for (int k = 0; k < 5; k++) add(0, 1'b1, 24'h000300 + 24'(k), 16'(k));
        repeat (10) @(posedge clk);
        #2;
        chk(hs_log.size() == DEPTH, "t4_full_count", hs_log.size(), DEPTH);
        @(negedge clk);
        chk(a_ready == '0, "t4_ready_low", a_ready, 0);
        @(posedge clk);
        one_shot = 1'b1;
        @(posedge clk);
        #2;
        chk(hs_log.size() == DEPTH, "t4_no_push_on_pop", hs_log.size(), DEPTH);
        @(posedge clk);
        #2;
        chk(hs_log.size() == DEPTH + 1, "t4_push_after_pop", hs_log.size(), DEPTH + 1);
        resp_prob = 100;
        wait_idle(100);

        // T5: spurious response raises a sticky error.
        do_reset();
        start_test();
        spur_req = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(err && b_valid == '0, "t5_err_sticky", {err, b_valid}, 4);
        do_reset();
        @(negedge clk);
        chk(!err, "t5_err_cleared", err, 0);

        // T6: reset with accesses outstanding, arbitration restarts at requester 0.
        resp_prob = 0;
        start_test();
        for (int k = 0; k < 3; k++) add(0, 1'b1, 24'h000400 + 24'(k), 16'(k));
        repeat (6) @(posedge clk);
        #2;
        chk(hs_log.size() == 3, "t6_outstanding", hs_log.size(), 3);
        do_reset();
        start_test();
        add(1, 1'b0, 24'h000400, 16'h0);
        for (int k = 0; k < 5; k++) add(0, 1'b1, 24'h000500 + 24'(k), 16'(k));
        repeat (10) @(posedge clk);
        #2;
        chk(hs_log.size() == DEPTH, "t6_count_cleared", hs_log.size(), DEPTH);
        chk(hs_log.size() > 0 && hs_log[0].owner == 0, "t6_grant0", hs_log.size() > 0 ? hs_log[0].owner : -1, 0);
        resp_prob = 100;
        wait_idle(100);

        // T7: randomized traffic, back-pressure and response delay.
        do_reset();
        start_test();
        aready_prob = 70;
        resp_prob = 60;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            for (int i = 0; i < NREQ; i++)
                if (req_q[i].size() < 3 && $urandom_range(99) < 30)
                    add(i, 1'($urandom_range(1)),
                        24'($urandom_range(15)) | ($urandom_range(1) ? 24'hFFFFF0 : 24'h0),
                        16'($urandom));
        end
        aready_prob = 100;
        resp_prob = 100;
        wait_idle(500);
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
